// File: rtl/bin_neuron_seq.sv
// -----------------------------------------------------------------------------
// bin_neuron_seq
//
// Sequential binary-pixel weighted-sum neuron. It accepts one frame (N_IN pixel
// bits, N_IN signed weights and a signed bias) over a valid/ready handshake. It
// then adds the weight of every set pixel to the bias, one pixel per clock,
// through a single ACC_W-bit adder. The registered result is returned over a
// second valid/ready handshake.
//
// Build option:
//   BIN_NEURON_SAT_EN  defined   -> narrowing to W bits saturates
//                      undefined -> narrowing wraps (keeps the low W bits)
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset
//   in_valid   frame operands valid
//   in_ready   block is idle and can accept a frame
//   x_vec      pixel bits, bit i = pixel i
//   w_flat     packed signed weights, weight i = w_flat[i*W +: W]
//   bias       signed bias
//   out_valid  result valid (held until out_ready)
//   out_ready  downstream accepts the result
//   out_data   signed W-bit result
//   out_act    1 when out_data > 0 (signed)
// -----------------------------------------------------------------------------
module bin_neuron_seq #(
    parameter int N_IN = 9,
    parameter int W    = 20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N_IN-1:0]     x_vec,
    input  logic [N_IN*W-1:0]   w_flat,
    input  logic [W-1:0]        bias,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [W-1:0]        out_data,
    output logic                out_act
);

    // Enough headroom for N_IN weights plus the bias, so the sum never overflows.
    localparam int ACC_W = W + $clog2(N_IN + 1);
    localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_IN - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [N_IN-1:0]           x_q, x_d;
    logic [N_IN*W-1:0]         w_q, w_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [W-1:0]              out_data_q, out_data_d;
    logic                      out_act_q, out_act_d;

    logic [W-1:0]              w_sel;
    logic signed [ACC_W-1:0]   addend;
    logic signed [ACC_W-1:0]   sum;
    logic [W-1:0]              narrowed;

    // Reduce the wide accumulator to the W-bit result.
    function automatic logic [W-1:0] narrow(input logic signed [ACC_W-1:0] a);
`ifdef BIN_NEURON_SAT_EN
        localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
        localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-W+1){1'b1}}, {(W-1){1'b0}}};
        if (a > MAX_V)      return MAX_V[W-1:0];
        else if (a < MIN_V) return MIN_V[W-1:0];
        else                return a[W-1:0];
`else
        return a[W-1:0];
`endif
    endfunction

    // Single shared adder: the current pixel gates its sign-extended weight.
    assign w_sel    = w_q[idx_q*W +: W];
    assign addend   = x_q[idx_q] ? {{(ACC_W-W){w_sel[W-1]}}, w_sel} : '0;
    assign sum      = acc_q + addend;
    assign narrowed = narrow(sum);

    always_comb begin
        // NOTE: every _d gets a default first, so no path through this block can infer a latch.
        state_d    = state_q;
        x_d        = x_q;
        w_d        = w_q;
        acc_d      = acc_q;
        idx_d      = idx_q;
        out_data_d = out_data_q;
        out_act_d  = out_act_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_d     = x_vec;
                    w_d     = w_flat;
                    acc_d   = {{(ACC_W-W){bias[W-1]}}, bias};
                    idx_d   = '0;
                    state_d = ACC;
                end
            end
            ACC: begin
                acc_d = sum;
                if (idx_q == IDX_LAST) begin
                    // Result is registered on the same edge as the final add.
                    out_data_d = narrowed;
                    out_act_d  = !narrowed[W-1] && (|narrowed);
                    state_d    = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values computed above.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            x_q        <= '0;
            w_q        <= '0;
            acc_q      <= '0;
            idx_q      <= '0;
            out_data_q <= '0;
            out_act_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            w_q        <= w_d;
            acc_q      <= acc_d;
            idx_q      <= idx_d;
            out_data_q <= out_data_d;
            out_act_q  <= out_act_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_data  = out_data_q;
    assign out_act   = out_act_q;

endmodule

// File: tb/tb_bin_neuron_seq.sv
// -----------------------------------------------------------------------------
// tb_bin_neuron_seq
//
// Directed self-checking bench for bin_neuron_seq (N_IN=9, W=20). Expected
// results are hand-computed. The wrap/saturate case follows BIN_NEURON_SAT_EN.
// -----------------------------------------------------------------------------
module tb_bin_neuron_seq;

    localparam int N_IN = 9;
    localparam int W    = 20;
    localparam int MAX_WAIT = 40;

    logic                clk;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [N_IN-1:0]     x_vec;
    logic [N_IN*W-1:0]   w_flat;
    logic [W-1:0]        bias;
    logic                out_valid;
    logic                out_ready;
    logic [W-1:0]        out_data;
    logic                out_act;

    int checks   = 0;
    int failures = 0;

    logic signed [W-1:0] wv [N_IN];

    bin_neuron_seq #(.N_IN(N_IN), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_vec     (x_vec),
        .w_flat    (w_flat),
        .bias      (bias),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_act   (out_act)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [N_IN*W-1:0] pack_w();
        logic [N_IN*W-1:0] r;
        for (int i = 0; i < N_IN; i++) r[i*W +: W] = wv[i];
        return r;
    endfunction

    // Present a frame while the block is idle, then scramble the inputs after the
    // accept edge. lat = edges from accept until out_valid, or -1 on timeout.
    task automatic run_frame(input logic [N_IN-1:0] x, input logic [N_IN*W-1:0] w,
                             input logic [W-1:0] b, output int lat);
        x_vec = x; w_flat = w; bias = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; x_vec = ~x; w_flat = ~w; bias = ~b;
        lat = -1;
        for (int c = 1; c <= MAX_WAIT; c++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        x_vec = '0; w_flat = '0; bias = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 20'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=00000", out_data); end
        checks++; if (out_act !== 1'b0) begin failures++; $display("FAIL reset_out_act got=%b exp=0", out_act); end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_all_set();
        int lat;
        for (int i = 0; i < N_IN; i++) wv[i] = W'(i + 1);
        run_frame(9'h1FF, pack_w(), -20'sd5, lat);
        checks++; if (lat !== N_IN) begin failures++; $display("FAIL all_set_latency got=%0d exp=%0d", lat, N_IN); end
        checks++; if (out_data !== 20'd40) begin failures++; $display("FAIL all_set_data got=%0d exp=40", $signed(out_data)); end
        checks++; if (out_act !== 1'b1) begin failures++; $display("FAIL all_set_act got=%b exp=1", out_act); end
        take_result();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL all_set_handshake got valid=%b ready=%b exp valid=0 ready=1", out_valid, in_ready); end
        checks++; if (out_data !== 20'd40) begin failures++; $display("FAIL all_set_data_kept got=%0d exp=40", $signed(out_data)); end
    endtask

    task automatic test_zero_pixels();
        int lat;
        for (int i = 0; i < N_IN; i++) wv[i] = 20'sd12345;
        run_frame(9'h000, pack_w(), -20'sd3, lat);
        checks++; if (lat !== N_IN) begin failures++; $display("FAIL zero_latency got=%0d exp=%0d", lat, N_IN); end
        checks++; if (out_data !== 20'hFFFFD) begin failures++; $display("FAIL zero_data got=%h exp=FFFFD", out_data); end
        checks++; if (out_act !== 1'b0) begin failures++; $display("FAIL zero_act got=%b exp=0", out_act); end
        take_result();
    endtask

    task automatic test_mixed();
        int lat;
        for (int i = 0; i < N_IN; i++) wv[i] = 20'sd1000;
        wv[0] = -20'sd100;
        wv[2] = 20'sd30;
        run_frame(9'b000000101, pack_w(), 20'sd0, lat);
        checks++; if (lat !== N_IN) begin failures++; $display("FAIL mixed_latency got=%0d exp=%0d", lat, N_IN); end
        checks++; if (out_data !== 20'hFFFBA) begin failures++; $display("FAIL mixed_data got=%0d exp=-70", $signed(out_data)); end
        checks++; if (out_act !== 1'b0) begin failures++; $display("FAIL mixed_act got=%b exp=0", out_act); end
        take_result();
    endtask

    task automatic test_wrap();
        int lat;
        logic [W-1:0] exp_data;
`ifdef BIN_NEURON_SAT_EN
        exp_data = 20'd524287;
`else
        exp_data = 20'd524279;
`endif
        for (int i = 0; i < N_IN; i++) wv[i] = 20'h7FFFF;
        run_frame(9'h1FF, pack_w(), 20'sd0, lat);
        checks++; if (lat !== N_IN) begin failures++; $display("FAIL wrap_latency got=%0d exp=%0d", lat, N_IN); end
        checks++; if (out_data !== exp_data) begin failures++; $display("FAIL wrap_data got=%0d exp=%0d", out_data, exp_data); end
        checks++; if (out_act !== 1'b1) begin failures++; $display("FAIL wrap_act got=%b exp=1", out_act); end
        take_result();
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [N_IN*W-1:0] wb;
        // Frame A: pixels 4..7 with weights 10*i, bias 7 -> 40+50+60+70+7 = 227.
        for (int i = 0; i < N_IN; i++) wv[i] = W'(10 * i);
        run_frame(9'h0F0, pack_w(), 20'sd7, lat);
        checks++; if (lat !== N_IN) begin failures++; $display("FAIL bp_latency got=%0d exp=%0d", lat, N_IN); end
        // Frame B: only pixel 8 (weight -50), bias 20 -> -30.
        for (int i = 0; i < N_IN; i++) wv[i] = 20'sd3;
        wv[8] = -20'sd50;
        wb = pack_w();
        x_vec = 9'h100; w_flat = wb; bias = 20'sd20; in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== 20'd227 || out_act !== 1'b1 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold cycle=%0d got valid=%b data=%0d act=%b ready=%b exp valid=1 data=227 act=1 ready=0",
                         c, out_valid, $signed(out_data), out_act, in_ready);
            end
        end
        take_result();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL bp_release got valid=%b ready=%b exp valid=0 ready=1", out_valid, in_ready); end
        run_frame(9'h100, wb, 20'sd20, lat);
        checks++; if (lat !== N_IN) begin failures++; $display("FAIL bp_next_latency got=%0d exp=%0d", lat, N_IN); end
        checks++; if (out_data !== 20'hFFFE2 || out_act !== 1'b0) begin failures++; $display("FAIL bp_next_data got=%0d act=%b exp=-30 act=0", $signed(out_data), out_act); end
        take_result();
    endtask

    task automatic test_abort();
        int lat;
        for (int i = 0; i < N_IN; i++) wv[i] = 20'sd1000;
        x_vec = 9'h1FF; w_flat = pack_w(); bias = 20'sd0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL abort_busy got ready=%b exp=0", in_ready); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 20'h0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL abort_reset got valid=%b data=%h ready=%b exp valid=0 data=00000 ready=1", out_valid, out_data, in_ready);
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        // Fresh frame: pixels 0,1 with weights 5,7, bias 1 -> 13.
        wv[0] = 20'sd5;
        wv[1] = 20'sd7;
        run_frame(9'h003, pack_w(), 20'sd1, lat);
        checks++; if (lat !== N_IN) begin failures++; $display("FAIL abort_next_latency got=%0d exp=%0d", lat, N_IN); end
        checks++; if (out_data !== 20'd13 || out_act !== 1'b1) begin failures++; $display("FAIL abort_next_data got=%0d act=%b exp=13 act=1", $signed(out_data), out_act); end
        take_result();
    endtask

    initial begin
        test_reset();
        test_all_set();
        test_zero_pixels();
        test_mixed();
        test_wrap();
        test_back_to_back();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
